// File: rtl/dmem_access_unit.sv
// MEM-stage load/store responder: turns one MemRead/MemWrite into a req/ack
// transaction on a variable-latency data-memory port, stalling until done.
module dmem_access_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_d;
  logic [CW-1:0] count;
  logic [1:0]  lane, lane_q;
  logic [2:0]  f3_q;
  logic        is_load_q;
  logic        req, misaligned;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign req  = MemRead | MemWrite;
  assign lane = addr[1:0];

  // Size comes from Funct3[1:0]; stores never fault on the unsigned codes.
  always_comb begin
    misaligned = 1'b0;
    be_c       = '0;
    wdata_c    = wdata;
    if (!MemWrite && (Funct3 == 3'b011 || Funct3[2:1] == 2'b11))
      misaligned = 1'b1;
    case (Funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << lane;
        wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << lane;
        wdata_c = {2{wdata[15:0]}};
        if (lane[0]) misaligned = 1'b1;
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = wdata;
        if (lane != 2'b00) misaligned = 1'b1;
      end
    endcase
  end

  assign byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
  assign half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (f3_q)
      3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  ext = {24'h0, byte_sel};
      3'b101:  ext = {16'h0, half_sel};
      default: ext = mem_rdata;
    endcase
  end

  // stall is gated by reset so it drops while reset is held with a request present.
  always_comb begin
    state_d = state;
    stall   = 1'b0;
    case (state)
      IDLE: if (req && !misaligned) begin
        stall   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_ack || count == LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!reset) stall = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata     <= '0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      count     <= '0;
      lane_q    <= '0;
      f3_q      <= '0;
      is_load_q <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: if (req) begin
          if (misaligned) begin
            err   <= 1'b1;
            rdata <= '0;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;
            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mem_be    <= be_c;
            mem_wdata <= wdata_c;
            count     <= '0;
            lane_q    <= lane;
            f3_q      <= Funct3;
            is_load_q <= ~MemWrite;
          end
        end
        WAIT: begin
          count <= count + 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (is_load_q) rdata <= ext;
          end else if (count == LAST) begin
            mem_req <= 1'b0;
            rdata   <= '0;
            err     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed self-checking bench for dmem_access_unit (TIMEOUT=16).
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, err, mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  dmem_access_unit #(.ADDR_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Stimulus only: present a request at a falling edge.
  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Funct3 = f3; addr = a; wdata = wd;
  endtask

  task automatic release_req();
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010;
    addr = 32'h100; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    #12;
    total_cnt++;
    if ({stall, err, mem_req, mem_we, mem_be} !== 8'h00 || rdata !== 32'h0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0)
      $display("FAIL reset_outputs: stall=%b err=%b req=%b we=%b be=%b rdata=%h addr=%h wd=%h, required all zero",
               stall, err, mem_req, mem_we, mem_be, rdata, mem_addr, mem_wdata);
    else pass_cnt++;
    MemRead = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lw();
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    #1;
    total_cnt++;
    if (stall !== 1'b1 || mem_req !== 1'b0)
      $display("FAIL lw_cycle0: stall=%b req=%b, required stall=1 req=0", stall, mem_req);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b1111 || mem_we !== 1'b0 || stall !== 1'b1)
      $display("FAIL lw_request: req=%b addr=%h be=%b we=%b stall=%b, required 1 00000100 1111 0 1",
               mem_req, mem_addr, mem_be, mem_we, stall);
    else pass_cnt++;
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      total_cnt++;
      if (mem_req !== 1'b1 || stall !== 1'b1 || mem_addr !== 32'h100)
        $display("FAIL lw_hold_c%0d: req=%b stall=%b addr=%h, required 1 1 00000100", c, mem_req, stall, mem_addr);
      else pass_cnt++;
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    total_cnt++;
    if (stall !== 1'b1)
      $display("FAIL lw_stall_ack_cycle: stall=%b, required 1", stall);
    else pass_cnt++;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    total_cnt++;
    if (rdata !== 32'hDEADBEEF || stall !== 1'b0 || mem_req !== 1'b0 || err !== 1'b0)
      $display("FAIL lw_done: rdata=%h stall=%b req=%b err=%b, required deadbeef 0 0 0", rdata, stall, mem_req, err);
    else pass_cnt++;
    release_req();
    total_cnt++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'hDEADBEEF)
      $display("FAIL lw_no_reissue: req=%b stall=%b rdata=%h, required 0 0 deadbeef", mem_req, stall, rdata);
    else pass_cnt++;
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] adrs [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] mrd  [4] = '{32'h80000000, 32'h80000000, 32'h80017F00, 32'h80017F00};
    logic [3:0]  bes  [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100};
    logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, f3s[i], adrs[i], 32'h0);
      @(negedge clk);
      total_cnt++;
      if (mem_be !== bes[i] || mem_addr !== 32'h100 || mem_req !== 1'b1)
        $display("FAIL ext%0d_request: be=%b addr=%h req=%b, required %b 00000100 1", i, mem_be, mem_addr, mem_req, bes[i]);
      else pass_cnt++;
      mem_ack = 1'b1; mem_rdata = mrd[i];
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = '0;
      total_cnt++;
      if (rdata !== exps[i] || stall !== 1'b0)
        $display("FAIL ext%0d_rdata: rdata=%h stall=%b, required %h 0", i, rdata, stall, exps[i]);
      else pass_cnt++;
      release_req();
    end
  endtask

  task automatic test_store();
    drive(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD);
    @(negedge clk);
    total_cnt++;
    if (mem_we !== 1'b1 || mem_be !== 4'b1100 || mem_wdata !== 32'hABCDABCD || mem_addr !== 32'h100)
      $display("FAIL sh_request: we=%b be=%b wd=%h addr=%h, required 1 1100 abcdabcd 00000100",
               mem_we, mem_be, mem_wdata, mem_addr);
    else pass_cnt++;
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    total_cnt++;
    if (rdata !== 32'h00008001 || stall !== 1'b0)
      $display("FAIL sh_rdata_hold: rdata=%h stall=%b, required 00008001 0", rdata, stall);
    else pass_cnt++;
    release_req();
    // Both controls set must behave as a byte store.
    drive(1'b1, 1'b1, 3'b000, 32'h201, 32'h000000A5);
    @(negedge clk);
    total_cnt++;
    if (mem_we !== 1'b1 || mem_be !== 4'b0010 || mem_wdata !== 32'hA5A5A5A5 || mem_addr !== 32'h200)
      $display("FAIL sb_request: we=%b be=%b wd=%h addr=%h, required 1 0010 a5a5a5a5 00000200",
               mem_we, mem_be, mem_wdata, mem_addr);
    else pass_cnt++;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    release_req();
  endtask

  task automatic test_misaligned();
    drive(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
    #1;
    total_cnt++;
    if (stall !== 1'b0)
      $display("FAIL mis_stall: stall=%b, required 0", stall);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (mem_req !== 1'b0 || err !== 1'b1 || rdata !== 32'h0)
      $display("FAIL mis_err: req=%b err=%b rdata=%h, required 0 1 00000000", mem_req, err, rdata);
    else pass_cnt++;
    release_req();
    total_cnt++;
    if (err !== 1'b0)
      $display("FAIL mis_err_pulse: err=%b, required 0", err);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int high = 0;
    drive(1'b0, 1'b1, 3'b010, 32'h300, 32'h11223344);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_req !== 1'b1) break;
      high++;
    end
    total_cnt++;
    if (high !== 16)
      $display("FAIL timeout_len: req_cycles=%0d, required 16", high);
    else pass_cnt++;
    total_cnt++;
    if (err !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL timeout_done: err=%b stall=%b req=%b, required 1 0 0", err, stall, mem_req);
    else pass_cnt++;
    release_req();
    total_cnt++;
    if (err !== 1'b0 || stall !== 1'b0)
      $display("FAIL timeout_after: err=%b stall=%b, required 0 0", err, stall);
    else pass_cnt++;
  endtask

  task automatic test_ack_at_timeout();
    drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    repeat (16) @(negedge clk);
    total_cnt++;
    if (mem_req !== 1'b1)
      $display("FAIL ackto_req: req=%b in 16th wait cycle, required 1", mem_req);
    else pass_cnt++;
    mem_ack = 1'b1; mem_rdata = 32'h55AA1234;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    total_cnt++;
    if (err !== 1'b0 || rdata !== 32'h55AA1234 || mem_req !== 1'b0 || stall !== 1'b0)
      $display("FAIL ackto_done: err=%b rdata=%h req=%b stall=%b, required 0 55aa1234 0 0",
               err, rdata, mem_req, stall);
    else pass_cnt++;
    release_req();
  endtask

  task automatic test_reset_midwait();
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || err !== 1'b0 || rdata !== 32'h0)
      $display("FAIL rst_async: req=%b stall=%b err=%b rdata=%h, required 0 0 0 00000000",
               mem_req, stall, err, rdata);
    else pass_cnt++;
    @(negedge clk);
    MemRead = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    total_cnt++;
    if (rdata !== 32'h0 || mem_req !== 1'b0 || stall !== 1'b0 || err !== 1'b0)
      $display("FAIL rst_stray_ack: rdata=%h req=%b stall=%b err=%b, required 00000000 0 0 0",
               rdata, mem_req, stall, err);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_misaligned();
    test_timeout();
    test_ack_at_timeout();
    test_reset_midwait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- MEM-stage responder for the MemRead/MemWrite control interface the decoder drives.
- Turns one pipeline load/store into a req/ack transaction on a variable-latency data-memory port.
- Stalls the pipeline until the transaction completes.
- Handles byte/half/word sizing, load sign/zero extension, misalignment detection and an ack timeout.

Parameters:
- ADDR_W, 32, byte address width
- TIMEOUT, 16, max cycles waiting for mem_ack before abort (>=2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- MemRead  in  1  load request from EX/MEM register
- MemWrite  in  1  store request from EX/MEM register
- Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  ADDR_W  byte address (ALU result)
- wdata  in  32  store data (rs2)
- rdata  out  32  extended load data, valid in DONE
- stall  out  1  freeze PC/IF/ID/EX/MEM registers
- err  out  1  one-cycle pulse: misaligned access or timeout
- mem_req  out  1  request to memory, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address (addr[1:0] forced 00)
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completion, one-cycle pulse
- mem_rdata  in  32  read word, valid with mem_ack

Behaviour:
- Reset (reset=0, async): state IDLE, counter 0; every output 0 immediately, including mem_req and stall. A transaction in flight is abandoned, and any later mem_ack from it is ignored in IDLE.
- States: IDLE, WAIT, DONE.
- IDLE, no MemRead/MemWrite: stall=0, mem_req=0.
- IDLE, request present and aligned:
  - stall=1 combinationally that cycle.
  - On the clock edge: register mem_we/addr/be/wdata, set mem_req=1, clear counter, go to WAIT.
- IDLE, request present but misaligned (H with addr[0]=1, W with addr[1:0]!=00, or reserved Funct3 on a load):
  - No memory request is issued.
  - stall=0.
  - err=1 next cycle for one cycle; rdata=0. Stays in IDLE.
- MemRead and MemWrite both set: treated as a store.
- WAIT:
  - stall=1, mem_req and all mem_* outputs held stable.
  - Counter increments each cycle.
  - mem_ack=1: capture the extended mem_rdata (loads only) into rdata, drop mem_req, go to DONE.
  - Counter reaches TIMEOUT-1 without ack: drop mem_req, rdata=0, err pulse, go to DONE.
  - Ack and timeout in the same cycle: ack wins, no err.
- DONE:
  - stall=0, so the pipeline advances this cycle.
  - rdata holds the result; go to IDLE unconditionally. The still-present request is not re-issued.
  - rdata holds its value until the next load completes.
- Minimum latency: request in cycle 0, mem_req high in cycle 1, ack in cycle 1, DONE in cycle 2. stall is high in cycles 0-1.
- Byte lanes (lane = addr[1:0]):
  - B: mem_be = 0001 << lane, mem_wdata = {4{wdata[7:0]}}.
  - H: mem_be = 0011 << lane, mem_wdata = {2{wdata[15:0]}}.
  - W: mem_be = 1111, mem_wdata = wdata.
  - Loads use mem_be of the same shape.
- Load extension: select the byte/half by lane from mem_rdata. B/H sign-extend, BU/HU zero-extend, W passes through.
- mem_ack outside WAIT is ignored.
- Inputs are required stable while stall=1. The unit does not re-sample them in WAIT.

Test Plan:
- Reset, then LW addr=0x100; mem_ack 3 cycles after mem_req with rdata 0xDEADBEEF.
  - Required: mem_addr=0x100, mem_be=1111, mem_we=0.
  - stall high from request cycle until ack+1.
  - DONE has rdata=0xDEADBEEF, stall=0; no second mem_req.
- LB addr=0x103 with mem_rdata 0x80000000 -> mem_be=1000, rdata=0xFFFFFF80. Same access as LBU -> rdata=0x00000080.
- SH addr=0x102 wdata=0x1234ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x100.
- LW addr=0x101 -> no mem_req, stall=0, err pulses 1 cycle, rdata=0.
- SW, mem_ack never returned, TIMEOUT=16 -> mem_req drops after 16 cycles in WAIT, err pulse, DONE, stall released.
- LW in WAIT, reset asserted mid-wait -> mem_req, stall, err go 0 asynchronously. A stray mem_ack after reset release leaves rdata=0 and state IDLE.
